// File: rtl/sync_fifo_pro_if.sv
// sync_fifo_pro_if
// Purpose: groups the producer/consumer side of sync_fifo_pro into one bundle.
// Ports (signals):
//   flush, data_in, wr_en, rd_en              -> driven by the user (master)
//   data_out, valid, full, empty, almost_full,
//   almost_empty, count, overflow, underflow  -> driven by the FIFO (slave)
interface sync_fifo_pro_if #(
    parameter int data_width = 8,
    parameter int fifo_depth = 16
);
    localparam int cnt_w = $clog2(fifo_depth) + 1;

    logic                  flush;
    logic [data_width-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [data_width-1:0] data_out;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [cnt_w-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, data_in, wr_en, rd_en,
        input  data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, data_in, wr_en, rd_en,
        output data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro
// Purpose: single-clock FIFO with occupancy count, almost-full/almost-empty
//   thresholds, optional first-word-fall-through read, synchronous flush and
//   sticky overflow/underflow flags.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - sync_fifo_pro_if.slave (write/read handshake, data, status)
module sync_fifo_pro #(
    parameter int data_width = 8,
    parameter int fifo_depth = 16,
    parameter int fwft       = 0,
    parameter int af_thresh  = 12,
    parameter int ae_thresh  = 4
) (
    input logic           clk,
    input logic           reset,
    sync_fifo_pro_if.slave bus
);
    localparam int aw = $clog2(fifo_depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] depth_lvl = cw'(fifo_depth);
    localparam logic [cw-1:0] af_lvl    = cw'(af_thresh);
    localparam logic [cw-1:0] ae_lvl    = cw'(ae_thresh);

    logic [data_width-1:0] mem [fifo_depth];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic [cw-1:0]         count_r;
    logic [data_width-1:0] data_r;
    logic                  valid_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  af_r;
    logic                  ae_r;
    logic                  ov_r;
    logic                  un_r;

    logic                  rd_ok;
    logic                  wr_ok;
    logic                  load;
    logic                  bypass;
    logic                  mem_we;
    logic [cw-1:0]         mem_cnt;
    logic [cw-1:0]         count_next;

    always_comb begin
        rd_ok      = 1'b0;
        wr_ok      = 1'b0;
        load       = 1'b0;
        bypass     = 1'b0;
        mem_we     = 1'b0;
        mem_cnt    = count_r;
        count_next = count_r;

        if (fwft != 0) begin
            rd_ok = bus.rd_en && valid_r;
        end else begin
            rd_ok = bus.rd_en && !empty_r;
        end
        wr_ok = bus.wr_en && (!full_r || rd_ok);

        if (fwft != 0) begin
            // In FWFT the head word lives in the output register, so memory
            // holds count minus that word.
            mem_cnt = count_r - {{(cw-1){1'b0}}, valid_r};
            if (!valid_r || rd_ok) begin
                if (mem_cnt != '0) begin
                    load = 1'b1;
                end else begin
                    // Memory empty while popping: a simultaneous write goes
                    // straight to the output register instead of memory.
                    bypass = rd_ok && wr_ok;
                end
            end
        end else begin
            load = rd_ok;
        end

        mem_we     = wr_ok && !bypass;
        count_next = count_r + {{(cw-1){1'b0}}, wr_ok} - {{(cw-1){1'b0}}, rd_ok};
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset && !bus.flush) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
            ov_r    <= 1'b0;
            un_r    <= 1'b0;
        end else if (bus.flush) begin
            // data_r deliberately holds its value across a flush
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
            ov_r    <= 1'b0;
            un_r    <= 1'b0;
        end else begin
            count_r <= count_next;
            full_r  <= (count_next == depth_lvl);
            empty_r <= (count_next == '0);
            af_r    <= (count_next >= af_lvl);
            ae_r    <= (count_next <= ae_lvl);
            ov_r    <= ov_r || (bus.wr_en && !wr_ok);
            un_r    <= un_r || (bus.rd_en && !rd_ok);

            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                data_r <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (bypass) begin
                data_r <= bus.data_in;
            end

            // Standard mode: valid is a one-cycle strobe per accepted read.
            // FWFT: the output register only changes when empty or popped.
            if ((fwft == 0) || !valid_r || rd_ok) begin
                valid_r <= load || bypass;
            end
        end
    end

    assign bus.data_out     = data_r;
    assign bus.valid        = valid_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = af_r;
    assign bus.almost_empty = ae_r;
    assign bus.count        = count_r;
    assign bus.overflow     = ov_r;
    assign bus.underflow    = un_r;
endmodule

// File: tb/tb_sync_fifo_pro.sv
// tb_sync_fifo_pro
// Purpose: exercises sync_fifo_pro in standard mode (scoreboard-checked) and
//   in FWFT mode (directed expectations), including thresholds, full/empty
//   boundaries, error flags, wrap-around, flush and reset.
module tb_sync_fifo_pro;
    localparam int dw    = 8;
    localparam int depth = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s;
    logic rst_f;

    sync_fifo_pro_if #(.data_width(dw), .fifo_depth(depth)) bs();
    sync_fifo_pro_if #(.data_width(dw), .fifo_depth(depth)) bf();

    sync_fifo_pro #(.data_width(dw), .fifo_depth(depth), .fwft(0),
                    .af_thresh(12), .ae_thresh(4))
        dut_s (.clk(clk), .reset(rst_s), .bus(bs.slave));

    sync_fifo_pro #(.data_width(dw), .fifo_depth(depth), .fwft(1),
                    .af_thresh(12), .ae_thresh(4))
        dut_f (.clk(clk), .reset(rst_f), .bus(bf.slave));

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];
    int  m_count;
    bit  m_ov;
    bit  m_un;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_count = 0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        sb.delete();
    endtask

    task automatic check_flags_s(input string tag);
        check({tag, "_count"}, 32'(bs.count), 32'(m_count));
        check({tag, "_full"},  32'(bs.full),  32'(m_count == depth));
        check({tag, "_empty"}, 32'(bs.empty), 32'(m_count == 0));
        check({tag, "_af"},    32'(bs.almost_full),  32'(m_count >= 12));
        check({tag, "_ae"},    32'(bs.almost_empty), 32'(m_count <= 4));
        check({tag, "_ovf"},   32'(bs.overflow),  32'(m_ov));
        check({tag, "_unf"},   32'(bs.underflow), 32'(m_un));
    endtask

    // One standard-mode cycle: drive, update the reference model, clock,
    // then compare status and any produced word against the scoreboard.
    task automatic cyc_s(input bit wr, input logic [7:0] din, input bit rd, input bit fl);
        bit rd_ok;
        bit wr_ok;
        bit exp_v;
        logic [7:0] exp_d;
        exp_v = 1'b0;
        bs.wr_en = wr; bs.rd_en = rd; bs.data_in = din; bs.flush = fl;
        if (fl) begin
            model_reset();
        end else begin
            rd_ok = rd && (m_count != 0);
            wr_ok = wr && ((m_count < depth) || rd_ok);
            if (rd && !rd_ok) m_un = 1'b1;
            if (wr && !wr_ok) m_ov = 1'b1;
            exp_v = rd_ok;
            if (wr_ok) sb.push_back(din);
            m_count = m_count + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        end
        tick();
        bs.wr_en = 1'b0; bs.rd_en = 1'b0; bs.flush = 1'b0;
        check_flags_s("s");
        check("s_valid", 32'(bs.valid), 32'(exp_v));
        if (bs.valid && exp_v) begin
            exp_d = sb.pop_front();
            check("s_data", 32'(bs.data_out), 32'(exp_d));
        end
    endtask

    task automatic fill_overflow_s(input logic [7:0] base);
        for (int i = 0; i < depth; i++) cyc_s(1'b1, base + 8'(i), 1'b0, 1'b0);
        cyc_s(1'b1, 8'h77, 1'b0, 1'b0);
    endtask

    task automatic drv_f(input bit wr, input logic [7:0] din, input bit rd, input bit fl);
        bf.wr_en = wr; bf.rd_en = rd; bf.data_in = din; bf.flush = fl;
        tick();
        bf.wr_en = 1'b0; bf.rd_en = 1'b0; bf.flush = 1'b0;
    endtask

    task automatic check_f(input string tag, input bit v, input logic [7:0] d, input int cnt);
        check({tag, "_valid"}, 32'(bf.valid), 32'(v));
        if (v) check({tag, "_data"}, 32'(bf.data_out), 32'(d));
        check({tag, "_count"}, 32'(bf.count), 32'(cnt));
        check({tag, "_empty"}, 32'(bf.empty), 32'(cnt == 0));
    endtask

    initial begin
        rst_s = 1'b1; rst_f = 1'b1;
        bs.flush = 0; bs.wr_en = 0; bs.rd_en = 0; bs.data_in = '0;
        bf.flush = 0; bf.wr_en = 0; bf.rd_en = 0; bf.data_in = '0;
        tick();
        tick();
        rst_s = 1'b0; rst_f = 1'b0;
        model_reset();

        // ---------------- standard mode ----------------
        check_flags_s("s_rst");
        check("s_rst_valid", 32'(bs.valid), 32'd0);
        check("s_rst_data",  32'(bs.data_out), 32'd0);

        for (int i = 0; i < depth; i++) cyc_s(1'b1, 8'(i), 1'b0, 1'b0);
        // full: simultaneous write+read is accepted, head 0x00 comes out
        cyc_s(1'b1, 8'hAA, 1'b1, 1'b0);
        check("s_full_wr_rd_data", 32'(bs.data_out), 32'h00);
        cyc_s(1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < depth; i++) cyc_s(1'b0, 8'h00, 1'b1, 1'b0);
        cyc_s(1'b0, 8'h00, 1'b1, 1'b0);
        cyc_s(1'b0, 8'h00, 1'b0, 1'b0);

        // wrap-around with shallow occupancy
        for (int k = 0; k < 40; k++) cyc_s(1'b1, 8'(k * 3 + 1), (k >= 2), 1'b0);
        cyc_s(1'b0, 8'h00, 1'b1, 1'b0);
        cyc_s(1'b0, 8'h00, 1'b1, 1'b0);
        cyc_s(1'b0, 8'h00, 1'b0, 1'b0);

        // flush at count 9 with overflow set; the concurrent write is dropped
        fill_overflow_s(8'h80);
        for (int i = 0; i < 7; i++) cyc_s(1'b0, 8'h00, 1'b1, 1'b0);
        check("s_pre_flush_count", 32'(bs.count), 32'd9);
        cyc_s(1'b1, 8'hEE, 1'b0, 1'b1);
        check("s_flush_wptr", 32'(dut_s.wr_ptr), 32'd0);
        cyc_s(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc_s(1'b0, 8'h00, 1'b1, 1'b0);

        // same with reset
        fill_overflow_s(8'h90);
        for (int i = 0; i < 7; i++) cyc_s(1'b0, 8'h00, 1'b1, 1'b0);
        bs.wr_en = 1'b1; bs.data_in = 8'hDD; rst_s = 1'b1;
        tick();
        bs.wr_en = 1'b0; rst_s = 1'b0;
        model_reset();
        check_flags_s("s_rst2");
        check("s_rst2_valid", 32'(bs.valid), 32'd0);
        check("s_rst2_data",  32'(bs.data_out), 32'd0);
        check("s_rst2_wptr",  32'(dut_s.wr_ptr), 32'd0);
        cyc_s(1'b1, 8'h5C, 1'b0, 1'b0);
        cyc_s(1'b0, 8'h00, 1'b1, 1'b0);

        // ---------------- FWFT mode ----------------
        check_f("f_rst", 1'b0, 8'h00, 0);
        check("f_rst_data", 32'(bf.data_out), 32'd0);

        drv_f(1'b1, 8'h5A, 1'b0, 1'b0);
        check_f("f_lat1", 1'b0, 8'h00, 1);
        drv_f(1'b0, 8'h00, 1'b0, 1'b0);
        check_f("f_lat2", 1'b1, 8'h5A, 1);
        drv_f(1'b0, 8'h00, 1'b1, 1'b0);
        check_f("f_pop", 1'b0, 8'h00, 0);
        check("f_pop_unf", 32'(bf.underflow), 32'd0);

        drv_f(1'b1, 8'h11, 1'b0, 1'b0);
        check_f("f_b1", 1'b0, 8'h00, 1);
        drv_f(1'b1, 8'h22, 1'b0, 1'b0);
        check_f("f_b2", 1'b1, 8'h11, 2);
        drv_f(1'b1, 8'h33, 1'b0, 1'b0);
        check_f("f_b3", 1'b1, 8'h11, 3);
        drv_f(1'b0, 8'h00, 1'b1, 1'b0);
        check_f("f_p1", 1'b1, 8'h22, 2);
        drv_f(1'b0, 8'h00, 1'b1, 1'b0);
        check_f("f_p2", 1'b1, 8'h33, 1);
        drv_f(1'b0, 8'h00, 1'b1, 1'b0);
        check_f("f_p3", 1'b0, 8'h00, 0);

        // pop with simultaneous write while memory is empty
        drv_f(1'b1, 8'h44, 1'b0, 1'b0);
        drv_f(1'b0, 8'h00, 1'b0, 1'b0);
        check_f("f_byp0", 1'b1, 8'h44, 1);
        drv_f(1'b1, 8'h55, 1'b1, 1'b0);
        check_f("f_byp1", 1'b1, 8'h55, 1);
        drv_f(1'b0, 8'h00, 1'b1, 1'b0);
        check_f("f_byp2", 1'b0, 8'h00, 0);

        drv_f(1'b0, 8'h00, 1'b1, 1'b0);
        check("f_unf", 32'(bf.underflow), 32'd1);
        check_f("f_unf", 1'b0, 8'h00, 0);

        for (int i = 0; i < depth; i++) drv_f(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        check_f("f_full", 1'b1, 8'hC0, 16);
        check("f_full_flag", 32'(bf.full), 32'd1);
        check("f_full_af", 32'(bf.almost_full), 32'd1);
        drv_f(1'b1, 8'hFF, 1'b0, 1'b0);
        check("f_ovf", 32'(bf.overflow), 32'd1);
        check_f("f_ovf", 1'b1, 8'hC0, 16);
        drv_f(1'b1, 8'hBB, 1'b1, 1'b0);
        check_f("f_full_wr_rd", 1'b1, 8'hC1, 16);
        drv_f(1'b1, 8'hEE, 1'b1, 1'b1);
        check_f("f_flush", 1'b0, 8'h00, 0);
        check("f_flush_ovf", 32'(bf.overflow), 32'd0);
        check("f_flush_unf", 32'(bf.underflow), 32'd0);
        check("f_flush_ae", 32'(bf.almost_empty), 32'd1);
        drv_f(1'b1, 8'h6B, 1'b0, 1'b0);
        drv_f(1'b0, 8'h00, 1'b0, 1'b0);
        check_f("f_after_flush", 1'b1, 8'h6B, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sync_fifo_pro.md
Name: sync_fifo_pro

Overview:
Single-clock, parametrised FIFO that replaces the plain pointer-compare FIFO in single-domain datapaths. It adds:
- an occupancy count and programmable almost-full/almost-empty thresholds;
- a selectable first-word-fall-through (FWFT) read mode;
- synchronous flush;
- sticky overflow/underflow error flags.

It sits between producer and consumer logic sharing one clock, e.g. behind a CDC FIFO or in front of a packetiser.

Parameters:
data_width, 8, width of each stored word
fifo_depth, 16, total capacity in words; power of two, >= 4
fwft, 0, 0 = standard registered read, 1 = first-word-fall-through
af_thresh, 12, almost_full asserts when count >= af_thresh; range 1..fifo_depth
ae_thresh, 4, almost_empty asserts when count <= ae_thresh; range 0..fifo_depth-1

Ports:
clk  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous empty request
data_in  input  data_width  write data
wr_en  input  1  write request
rd_en  input  1  read request (standard) / pop (FWFT)
data_out  output  data_width  read data
valid  output  1  data_out holds a valid word
full  output  1  count == fifo_depth
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
count  output  clog2(fifo_depth)+1  words held, including any word presented on data_out in FWFT
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Clocking and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, data_out=0, overflow=0, underflow=0, pointers=0. Memory contents are not reset.
- Priority, highest first: reset, then flush, then wr/rd.
- Flush: sets count, pointers, valid, overflow and underflow to their reset values. data_out holds its value. wr_en and rd_en in that cycle are ignored and do not set error flags.
- rd_ok: standard mode = rd_en && !empty. FWFT mode = rd_en && valid.
- wr_ok = wr_en && (!full || rd_ok). A write into a full FIFO is accepted when a read is accepted in the same cycle.
- count: next count = count + wr_ok - rd_ok. All flags are registered and derived from the next count, so they change on the same edge as count.
- Pointers: binary, width clog2(fifo_depth); they wrap naturally from fifo_depth-1 to 0.
- Standard mode:
  - On rd_ok, data_out takes mem[rd_ptr] at the edge and valid=1 for exactly that following cycle; otherwise valid=0 and data_out holds.
  - Write-to-empty-deassert latency is 1 edge.
  - Simultaneous wr+rd while empty: the read is rejected and underflow is set; the write is accepted.
- FWFT mode:
  - One output register holds the head word; valid=1 whenever it is loaded.
  - A word written into an empty FIFO appears on data_out with valid=1 one edge after the write edge, i.e. 2 edges after wr_en is sampled. count=1 from the write edge.
  - On rd_ok, the output register reloads from memory the next edge if memory is non-empty, or from data_in if a write is simultaneous and memory is empty; otherwise valid=0.
  - Back-to-back pops sustain one word per cycle.
- Error flags:
  - overflow is set when wr_en && !wr_ok.
  - underflow is set when rd_en && !rd_ok.
  - Both are sticky until reset or flush.
- Reset or flush mid-burst: any in-flight read data is dropped (valid=0 next cycle) and the next write starts at pointer 0.

Test Plan:
- Reset then fill, depth 16: 16 writes of 0x00..0x0F. almost_full rises on the 12th write edge (count=12), full on the 16th. A 17th write keeps count=16, sets overflow=1, and leaves mem unchanged.
- Drain, standard mode: 16 reads return 0x00..0x0F, each one cycle after rd_en with valid=1. almost_empty rises at count=4, empty at count=0. An extra read sets underflow=1 and keeps valid=0.
- Full with simultaneous wr+rd: from full with head 0x00, write 0xAA and read in one cycle. count stays 16, data_out=0x00, no overflow, and 0xAA is read out 16th.
- FWFT latency: with fwft=1 and the FIFO empty, write 0x5A at edge N. count=1 after N; data_out=0x5A with valid=1 after N+1. A pop with no new write gives valid=0, empty=1.
- Wrap-around: 40 interleaved writes/reads of an incrementing pattern at count<=3. The output sequence matches the input exactly across 2+ pointer wraps.
- Flush and reset: at count=9 with overflow=1, assert flush together with wr_en. Next cycle count=0, empty=1, overflow=0, and the write is discarded. The same check applies with reset.
